// File: rtl/lock_seq_ctrl.sv
// Two-button combination lock sequencer: shifts in digits, compares against PASSWORD,
// then opens or counts a failure. Optional entry timeout: define LOCK_ENTRY_TIMEOUT_EN.
module lock_seq_ctrl #(
    parameter int              PW_LEN      = 7,
    parameter logic [PW_LEN-1:0] PASSWORD  = 7'b0110110,
    parameter int              MAX_FAIL    = 3,
    parameter int              UNLOCK_CYC  = 500,
    parameter int              LOCKOUT_CYC = 1000,
    parameter int              TIMEOUT_CYC = 2000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              b0_in,
    input  logic              b1_in,
    output logic [PW_LEN-1:0] entry,
    output logic [3:0]        entry_cnt,
    output logic [3:0]        fail_cnt,
    output logic [1:0]        state,
    output logic              unlock,
    output logic              locked_out
);

    localparam int BASE_CYC = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
`ifdef LOCK_ENTRY_TIMEOUT_EN
    localparam int MAX_CYC  = (TIMEOUT_CYC > BASE_CYC) ? TIMEOUT_CYC : BASE_CYC;
`else
    localparam int MAX_CYC  = BASE_CYC;
`endif
    localparam int CNT_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ENTRY, ST_OPEN, ST_LOCKOUT} state_t;

    state_t              state_q, state_d;
    logic [PW_LEN-1:0]   entry_q, entry_d;
    logic [3:0]          entry_cnt_q, entry_cnt_d;
    logic [3:0]          fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0]    timer_q, timer_d;
    logic                unlock_q, unlock_d;
    logic                locked_out_q, locked_out_d;

    logic                digit, abort;
    logic [PW_LEN-1:0]   new_entry;
    logic [3:0]          new_cnt;
    logic [3:0]          fail_inc;

    assign digit = b0_in ^ b1_in;
    assign abort = b0_in & b1_in;

    // Timers are loaded with N-1 so the holding state lasts exactly N cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            entry_q      <= '0;
            entry_cnt_q  <= '0;
            fail_cnt_q   <= '0;
            timer_q      <= '0;
            unlock_q     <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            entry_q      <= entry_d;
            entry_cnt_q  <= entry_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            timer_q      <= timer_d;
            unlock_q     <= unlock_d;
            locked_out_q <= locked_out_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        entry_d     = entry_q;
        entry_cnt_d = entry_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        timer_d     = timer_q;

        // In IDLE the register restarts from zero, which also covers PW_LEN == 1.
        new_entry = ((state_q == ST_IDLE) ? '0 : (entry_q << 1)) | PW_LEN'(b1_in);
        new_cnt   = (state_q == ST_IDLE) ? 4'd1 : entry_cnt_q + 4'd1;
        fail_inc  = (fail_cnt_q >= 4'(MAX_FAIL)) ? fail_cnt_q : fail_cnt_q + 4'd1;

        case (state_q)
            ST_IDLE, ST_ENTRY: begin
                if (abort) begin
                    entry_d     = '0;
                    entry_cnt_d = '0;
                    state_d     = ST_IDLE;
                end else if (digit) begin
                    if (new_cnt == 4'(PW_LEN)) begin
                        entry_d     = '0;
                        entry_cnt_d = '0;
                        if (new_entry == PASSWORD) begin
                            state_d    = ST_OPEN;
                            fail_cnt_d = '0;
                            timer_d    = CNT_W'(UNLOCK_CYC - 1);
                        end else begin
                            fail_cnt_d = fail_inc;
                            if (fail_inc == 4'(MAX_FAIL)) begin
                                state_d = ST_LOCKOUT;
                                timer_d = CNT_W'(LOCKOUT_CYC - 1);
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end else begin
                        entry_d     = new_entry;
                        entry_cnt_d = new_cnt;
                        state_d     = ST_ENTRY;
`ifdef LOCK_ENTRY_TIMEOUT_EN
                        timer_d     = CNT_W'(TIMEOUT_CYC - 1);
`endif
                    end
                end
`ifdef LOCK_ENTRY_TIMEOUT_EN
                else if (state_q == ST_ENTRY) begin
                    if (timer_q == '0) begin
                        entry_d     = '0;
                        entry_cnt_d = '0;
                        state_d     = ST_IDLE;
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end
`endif
            end
            ST_OPEN: begin
                if (timer_q == '0) state_d = ST_IDLE;
                else               timer_d = timer_q - CNT_W'(1);
            end
            ST_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d    = ST_IDLE;
                    fail_cnt_d = '0;
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        unlock_d     = (state_d == ST_OPEN);
        locked_out_d = (state_d == ST_LOCKOUT);
    end

    assign entry      = entry_q;
    assign entry_cnt  = entry_cnt_q;
    assign fail_cnt   = fail_cnt_q;
    assign state      = state_q;
    assign unlock     = unlock_q;
    assign locked_out = locked_out_q;

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// Directed bench for lock_seq_ctrl: table-driven vectors plus hand sequences
// for lockout, asynchronous reset and entry timeout.
module tb_lock_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       b0_in, b1_in;
    logic [6:0] entry;
    logic [3:0] entry_cnt, fail_cnt;
    logic [1:0] state;
    logic       unlock, locked_out;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [6:0] PW  = 7'b0110110;
    localparam logic [6:0] BAD = 7'b1111111;

    lock_seq_ctrl #(
        .PW_LEN(7), .PASSWORD(7'b0110110), .MAX_FAIL(3),
        .UNLOCK_CYC(8), .LOCKOUT_CYC(16), .TIMEOUT_CYC(20)
    ) dut (
        .clk(clk), .reset(reset), .b0_in(b0_in), .b1_in(b1_in),
        .entry(entry), .entry_cnt(entry_cnt), .fail_cnt(fail_cnt),
        .state(state), .unlock(unlock), .locked_out(locked_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       b0, b1;
        logic [6:0] entry;
        logic [3:0] cnt, fail;
        logic [1:0] st;
        logic       unl, lo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic b0, logic b1, logic [6:0] e, logic [3:0] c,
                                logic [3:0] f, logic [1:0] s, logic u, logic l);
        vec_t v;
        v.b0 = b0; v.b1 = b1; v.entry = e; v.cnt = c; v.fail = f;
        v.st = s; v.unl = u; v.lo = l;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [6:0] e, input logic [3:0] c,
                             input logic [3:0] f, input logic [1:0] s, input logic u, input logic l);
        check({tag, ".entry"},      int'(entry),      int'(e));
        check({tag, ".entry_cnt"},  int'(entry_cnt),  int'(c));
        check({tag, ".fail_cnt"},   int'(fail_cnt),   int'(f));
        check({tag, ".state"},      int'(state),      int'(s));
        check({tag, ".unlock"},     int'(unlock),     int'(u));
        check({tag, ".locked_out"}, int'(locked_out), int'(l));
    endtask

    // Pulse held across exactly one rising edge; outputs sampled 1 time unit later.
    task automatic step(input logic b0, input logic b1);
        @(negedge clk);
        b0_in = b0;
        b1_in = b1;
        @(posedge clk);
        #1;
        b0_in = 1'b0;
        b1_in = 1'b0;
    endtask

    task automatic enter_bits(input logic [6:0] bits);
        for (int i = 6; i >= 0; i--) step(~bits[i], bits[i]);
    endtask

    task automatic add_correct(input logic [3:0] fail_before);
        vecs.push_back(mk(1, 0, 7'b0000000, 1, fail_before, 1, 0, 0));
        vecs.push_back(mk(0, 1, 7'b0000001, 2, fail_before, 1, 0, 0));
        vecs.push_back(mk(0, 1, 7'b0000011, 3, fail_before, 1, 0, 0));
        vecs.push_back(mk(1, 0, 7'b0000110, 4, fail_before, 1, 0, 0));
        vecs.push_back(mk(0, 1, 7'b0001101, 5, fail_before, 1, 0, 0));
        vecs.push_back(mk(0, 1, 7'b0011011, 6, fail_before, 1, 0, 0));
        vecs.push_back(mk(1, 0, 7'b0000000, 0, 0,           2, 1, 0));
    endtask

    initial begin
        b0_in = 1'b0;
        b1_in = 1'b0;
        reset = 1'b1;

        // Correct entry, then OPEN with presses (and an abort) ignored; expiry press ignored.
        add_correct(0);
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(1'b1, (i == 2), 0, 0, 0, 2, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
        // Wrong entry 1111111.
        vecs.push_back(mk(0, 1, 7'b0000001, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 7'b0000011, 2, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 7'b0000111, 3, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 7'b0001111, 4, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 7'b0011111, 5, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 7'b0111111, 6, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 7'b0000000, 0, 1, 0, 0, 0));
        // Abort after 0,1,1 keeps fail_cnt.
        vecs.push_back(mk(1, 0, 7'b0000000, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 7'b0000001, 2, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 7'b0000011, 3, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 7'b0000000, 0, 1, 0, 0, 0));
        // Correct entry unlocks and clears fail_cnt, then drains OPEN.
        add_correct(1);
        for (int i = 0; i < 7; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].b0, vecs[i].b1);
            $display("vec %0d: b0=%0b b1=%0b state=%0d cnt=%0d fail=%0d unlock=%0b",
                     i, vecs[i].b0, vecs[i].b1, state, entry_cnt, fail_cnt, unlock);
            check_all($sformatf("vec%0d", i), vecs[i].entry, vecs[i].cnt, vecs[i].fail,
                      vecs[i].st, vecs[i].unl, vecs[i].lo);
        end

        // Lockout after three consecutive failures.
        enter_bits(BAD);
        enter_bits(BAD);
        check("lock.fail2", int'(fail_cnt), 2);
        check("lock.state2", int'(state), 0);
        enter_bits(BAD);
        $display("lockout entered: state=%0d fail=%0d locked_out=%0b", state, fail_cnt, locked_out);
        check_all("lock.enter", 0, 0, 3, 3, 0, 1);
        for (int i = 1; i < 16; i++) begin
            step(1, 0);
            check($sformatf("lock.hold%0d.lo", i), int'(locked_out), 1);
            check($sformatf("lock.hold%0d.cnt", i), int'(entry_cnt), 0);
        end
        step(0, 1);
        $display("lockout expired: state=%0d fail=%0d locked_out=%0b", state, fail_cnt, locked_out);
        check_all("lock.exit", 0, 0, 0, 0, 0, 0);
        enter_bits(PW);
        check_all("lock.unlock", 0, 0, 0, 2, 1, 0);
        repeat (8) step(0, 0);
        check("lock.drain", int'(state), 0);

        // Asynchronous reset three cycles into OPEN.
        enter_bits(PW);
        step(0, 0);
        step(0, 0);
        check("rst.pre_unlock", int'(unlock), 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        $display("async reset: unlock=%0b state=%0d", unlock, state);
        check_all("rst.async", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // Entry inactivity timeout.
        step(1, 0);
        step(0, 1);
        check("tmo.cnt_start", int'(entry_cnt), 2);
        for (int i = 0; i < 19; i++) step(0, 0);
        check("tmo.cnt_19", int'(entry_cnt), 2);
        step(0, 0);
        $display("after 20 idle cycles: state=%0d cnt=%0d", state, entry_cnt);
`ifdef LOCK_ENTRY_TIMEOUT_EN
        check_all("tmo.expired", 0, 0, 0, 0, 0, 0);
`else
        check_all("tmo.waiting", 7'b0000001, 2, 0, 1, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
